bht_predictor: RTL and testbench

- Direct-mapped branch history table with branch target storage.
- Fetch stage performs a combinational lookup on the fetch PC and obtains a predicted direction, target and 2-bit counter state. That state travels down the pipeline registers alongside is_branch.
- Commit stage presents the carried state plus the resolved outcome. The table then updates the saturating counter, allocates entries, and counts branches and mispredictions.

---
 rtl/bht_pkg.sv | 17 +
 rtl/bht_predictor_if.sv | 29 ++
 rtl/bht_sat_counter.sv | 21 ++
 rtl/bht_predictor.sv | 109 ++++++++++
 tb/tb_bht_predictor.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bht_pkg.sv
// Shared definitions for branch-history predictor tables: counter encodings
// and the default PC width.
package bht_pkg;

    localparam int BHT_PC_W = 32;

    typedef enum logic [1:0] {
        BHT_SNT = 2'b00,
        BHT_WNT = 2'b01,
        BHT_WT  = 2'b10,
        BHT_ST  = 2'b11
    } bht_state_e;

    // Freshly allocated entries start weakly taken.
    localparam bht_state_e BHT_ALLOC = BHT_WT;

endpackage

// File: rtl/bht_predictor_if.sv
// Fetch-lookup and commit-update signal bundle between the pipeline (master)
// and the branch history table (slave).
interface bht_predictor_if #(
    parameter int PC_W = 32
);

    logic [PC_W-1:0] lk_pc;
    logic            lk_hit;
    logic            lk_taken;
    logic [PC_W-1:0] lk_target;
    logic [1:0]      lk_state;

    logic            upd_en;
    logic [PC_W-1:0] upd_pc;
    logic [1:0]      upd_state;
    logic            upd_taken;
    logic [PC_W-1:0] upd_target;

    modport master (
        output lk_pc, upd_en, upd_pc, upd_state, upd_taken, upd_target,
        input  lk_hit, lk_taken, lk_target, lk_state
    );

    modport slave (
        input  lk_pc, upd_en, upd_pc, upd_state, upd_taken, upd_target,
        output lk_hit, lk_taken, lk_target, lk_state
    );

endinterface

// File: rtl/bht_sat_counter.sv
// 2-bit saturating direction counter: next state from current state and the
// resolved outcome.
module bht_sat_counter
    import bht_pkg::*;
(
    input  logic [1:0] state,
    input  logic       taken,
    output logic [1:0] next_state
);

    always_comb begin
        // NOTE: default assigned first so every path drives next_state; no latch.
        next_state = state;
        if (taken && (state != BHT_ST)) begin
            next_state = state + 2'd1;
        end else if (!taken && (state != BHT_SNT)) begin
            next_state = state - 2'd1;
        end
    end

endmodule

// File: rtl/bht_predictor.sv
// Direct-mapped branch history table with target storage, combinational
// fetch lookup, commit-time update and saturating performance counters.
module bht_predictor
    import bht_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int PC_W  = BHT_PC_W,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    bht_predictor_if.slave   bus,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = PC_W - IDX_W - 2;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [1:0]       state_q  [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];

    logic [IDX_W-1:0] lk_idx, u_idx;
    logic [TAG_W-1:0] lk_tag, u_tag;
    logic             lk_match, u_hit, mispred;
    logic [1:0]       sat_next;
    logic             unused_pc_bits;

    assign lk_idx = bus.lk_pc[IDX_W+1:2];
    assign lk_tag = bus.lk_pc[PC_W-1:IDX_W+2];
    assign u_idx  = bus.upd_pc[IDX_W+1:2];
    assign u_tag  = bus.upd_pc[PC_W-1:IDX_W+2];
    assign unused_pc_bits = ^{bus.lk_pc[1:0], bus.upd_pc[1:0]};

    // Lookup reads the registered table only; same-cycle updates are not bypassed.
    assign lk_match      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign bus.lk_hit    = lk_match;
    assign bus.lk_state  = lk_match ? state_q[lk_idx]  : 2'b00;
    assign bus.lk_target = lk_match ? target_q[lk_idx] : '0;
    assign bus.lk_taken  = lk_match & state_q[lk_idx][1];

    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    // Direction comes from the carried state; a taken miss always counts.
    always_comb begin
        mispred = 1'b0;
        if (bus.upd_state[1] != bus.upd_taken) begin
            mispred = 1'b1;
        end else if (bus.upd_taken && !u_hit) begin
            mispred = 1'b1;
        end else if (bus.upd_taken && u_hit && (target_q[u_idx] != bus.upd_target)) begin
            mispred = 1'b1;
        end
    end

    bht_sat_counter u_sat (
        .state      (bus.upd_state),
        .taken      (bus.upd_taken),
        .next_state (sat_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: table lives in flops, not RAM, so reset and clear reach every entry.
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                state_q[i]  <= BHT_SNT;
                target_q[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (bus.upd_en) begin
            if (u_hit) begin
                state_q[u_idx] <= sat_next;
                if (bus.upd_taken) begin
                    target_q[u_idx] <= bus.upd_target;
                end
            end else if (bus.upd_taken) begin
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                state_q[u_idx]  <= BHT_ALLOC;
                target_q[u_idx] <= bus.upd_target;
            end
        end
    end

    // Counters still count updates whose table write was dropped by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking so both counters sample pre-edge values.
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (bus.upd_en) begin
            if (branch_cnt != '1) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (mispred && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bht_predictor.sv
// Self-checking bench for bht_predictor: scoreboarded lookup/counter checks per
// cycle, plus async-reset and 4-bit counter saturation scenarios.
module tb_bht_predictor;

    logic clk;
    logic rst_n;
    logic clear;
    logic clear4;
    logic [31:0] branch_cnt, mispred_cnt;
    logic [3:0]  branch_cnt4, mispred_cnt4;

    int nerr = 0;
    int nchk = 0;
    int eb   = 0;
    int em   = 0;

    typedef struct {
        string       name;
        logic        hit;
        logic [1:0]  st;
        logic [31:0] tgt;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t sbq[$];

    bht_predictor_if #(.PC_W(32)) bus  ();
    bht_predictor_if #(.PC_W(32)) bus4 ();

    bht_predictor #(.IDX_W(4), .PC_W(32), .CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .bus         (bus),
        .branch_cnt  (branch_cnt),
        .mispred_cnt (mispred_cnt)
    );

    bht_predictor #(.IDX_W(4), .PC_W(32), .CNT_W(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear4),
        .bus         (bus4),
        .branch_cnt  (branch_cnt4),
        .mispred_cnt (mispred_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // One cycle: drive after the edge, queue expectation, compare at the negedge.
    task automatic cyc(input string name, input logic [31:0] lk,
                       input logic ue, input logic [31:0] up, input logic [1:0] us,
                       input logic ut, input logic [31:0] utg, input logic clr,
                       input logic mis, input logic eh, input logic [1:0] es,
                       input logic [31:0] et);
        exp_t e, g;
        @(posedge clk);
        #1;
        bus.lk_pc      = lk;
        bus.upd_en     = ue;
        bus.upd_pc     = up;
        bus.upd_state  = us;
        bus.upd_taken  = ut;
        bus.upd_target = utg;
        clear          = clr;
        e.name = name;
        e.hit  = eh;
        e.st   = es;
        e.tgt  = et;
        e.bc   = 32'(eb);
        e.mc   = 32'(em);
        sbq.push_back(e);
        if (ue) begin
            eb++;
            if (mis) em++;
        end
        @(negedge clk);
        g = sbq.pop_front();
        nchk += 6;
        if (bus.lk_hit !== g.hit) begin
            nerr++; $display("FAIL %s.hit got=%b want=%b", g.name, bus.lk_hit, g.hit);
        end
        if (bus.lk_taken !== (g.hit & g.st[1])) begin
            nerr++; $display("FAIL %s.taken got=%b want=%b", g.name, bus.lk_taken, g.hit & g.st[1]);
        end
        if (bus.lk_state !== g.st) begin
            nerr++; $display("FAIL %s.state got=%b want=%b", g.name, bus.lk_state, g.st);
        end
        if (bus.lk_target !== g.tgt) begin
            nerr++; $display("FAIL %s.target got=%h want=%h", g.name, bus.lk_target, g.tgt);
        end
        if (branch_cnt !== g.bc) begin
            nerr++; $display("FAIL %s.branch_cnt got=%0d want=%0d", g.name, branch_cnt, g.bc);
        end
        if (mispred_cnt !== g.mc) begin
            nerr++; $display("FAIL %s.mispred_cnt got=%0d want=%0d", g.name, mispred_cnt, g.mc);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        nchk += 5;
        if (bus.lk_hit !== 1'b0) begin
            nerr++; $display("FAIL %s.hit got=%b want=0", name, bus.lk_hit);
        end
        if (bus.lk_state !== 2'b00) begin
            nerr++; $display("FAIL %s.state got=%b want=00", name, bus.lk_state);
        end
        if (bus.lk_target !== 32'h0) begin
            nerr++; $display("FAIL %s.target got=%h want=0", name, bus.lk_target);
        end
        if (branch_cnt !== 32'd0) begin
            nerr++; $display("FAIL %s.branch_cnt got=%0d want=0", name, branch_cnt);
        end
        if (mispred_cnt !== 32'd0) begin
            nerr++; $display("FAIL %s.mispred_cnt got=%0d want=0", name, mispred_cnt);
        end
    endtask

    task automatic test_reset();
        #2;
        bus.lk_pc = 32'h100;
        #1;
        check_zero_outputs("reset_hold");
        #9;
        rst_n = 1'b1;
    endtask

    task automatic test_cold_alloc();
        cyc("cold_miss",  32'h100, 1, 32'h100, 2'b00, 1, 32'h200, 0, 1, 0, 2'b00, 32'h0);
        cyc("cold_alloc", 32'h100, 0, 32'h0,   2'b00, 0, 32'h0,   0, 0, 1, 2'b10, 32'h200);
    endtask

    task automatic test_saturation();
        cyc("sat_t10",  32'h100, 1, 32'h100, 2'b10, 1, 32'h200, 0, 0, 1, 2'b10, 32'h200);
        cyc("sat_t11",  32'h100, 1, 32'h100, 2'b11, 1, 32'h200, 0, 0, 1, 2'b11, 32'h200);
        cyc("sat_hold", 32'h100, 1, 32'h100, 2'b11, 0, 32'h0,   0, 1, 1, 2'b11, 32'h200);
        cyc("sat_nt1",  32'h100, 1, 32'h100, 2'b10, 0, 32'h0,   0, 1, 1, 2'b10, 32'h200);
        cyc("sat_nt2",  32'h100, 1, 32'h100, 2'b01, 0, 32'h0,   0, 0, 1, 2'b01, 32'h200);
        cyc("sat_nt3",  32'h100, 1, 32'h100, 2'b00, 0, 32'h0,   0, 0, 1, 2'b00, 32'h200);
        cyc("sat_floor",32'h100, 0, 32'h0,   2'b00, 0, 32'h0,   0, 0, 1, 2'b00, 32'h200);
    endtask

    task automatic test_alias();
        cyc("alias_alloc", 32'h140, 1, 32'h140, 2'b00, 1, 32'h300, 0, 1, 0, 2'b00, 32'h0);
        cyc("alias_evict", 32'h100, 0, 32'h0,   2'b00, 0, 32'h0,   0, 0, 0, 2'b00, 32'h0);
        cyc("alias_new",   32'h140, 0, 32'h0,   2'b00, 0, 32'h0,   0, 0, 1, 2'b10, 32'h300);
        cyc("nt_miss",     32'h184, 1, 32'h184, 2'b00, 0, 32'h0,   0, 0, 0, 2'b00, 32'h0);
        cyc("nt_nochange", 32'h184, 0, 32'h0,   2'b00, 0, 32'h0,   0, 0, 0, 2'b00, 32'h0);
        cyc("tgt_wrong",   32'h140, 1, 32'h140, 2'b10, 1, 32'h340, 0, 1, 1, 2'b10, 32'h300);
        cyc("tgt_fixed",   32'h140, 0, 32'h0,   2'b00, 0, 32'h0,   0, 0, 1, 2'b11, 32'h340);
    endtask

    task automatic test_same_cycle();
        cyc("same_old", 32'h140, 1, 32'h140, 2'b11, 0, 32'h0, 0, 1, 1, 2'b11, 32'h340);
        cyc("same_new", 32'h140, 0, 32'h0,   2'b00, 0, 32'h0, 0, 0, 1, 2'b10, 32'h340);
    endtask

    task automatic test_clear();
        cyc("clr_upd",   32'h140, 1, 32'h184, 2'b00, 1, 32'h400, 1, 1, 1, 2'b10, 32'h340);
        cyc("clr_drop",  32'h184, 0, 32'h0,   2'b00, 0, 32'h0,   0, 0, 0, 2'b00, 32'h0);
        cyc("clr_gone",  32'h140, 0, 32'h0,   2'b00, 0, 32'h0,   0, 0, 0, 2'b00, 32'h0);
    endtask

    task automatic test_reset_mid();
        cyc("pre_rst_alloc", 32'h200, 1, 32'h200, 2'b00, 1, 32'h500, 0, 1, 0, 2'b00, 32'h0);
        cyc("pre_rst_hit",   32'h200, 0, 32'h0,   2'b00, 0, 32'h0,   0, 0, 1, 2'b10, 32'h500);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("rst_async");
        eb = 0;
        em = 0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        cyc("post_rst", 32'h200, 0, 32'h0, 2'b00, 0, 32'h0, 0, 0, 0, 2'b00, 32'h0);
    endtask

    task automatic test_cnt_sat();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            bus4.upd_en     = 1'b1;
            bus4.upd_pc     = 32'h100;
            bus4.upd_state  = 2'b00;
            bus4.upd_taken  = 1'b1;
            bus4.upd_target = 32'h200;
            @(negedge clk);
            if (i == 15) begin
                nchk += 2;
                if (branch_cnt4 !== 4'd15) begin
                    nerr++; $display("FAIL cnt4_reach.branch got=%0d want=15", branch_cnt4);
                end
                if (mispred_cnt4 !== 4'd15) begin
                    nerr++; $display("FAIL cnt4_reach.mispred got=%0d want=15", mispred_cnt4);
                end
            end
        end
        @(posedge clk);
        #1;
        bus4.upd_en = 1'b0;
        @(negedge clk);
        nchk += 2;
        if (branch_cnt4 !== 4'd15) begin
            nerr++; $display("FAIL cnt4_hold.branch got=%0d want=15", branch_cnt4);
        end
        if (mispred_cnt4 !== 4'd15) begin
            nerr++; $display("FAIL cnt4_hold.mispred got=%0d want=15", mispred_cnt4);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        clear           = 1'b0;
        clear4          = 1'b0;
        bus.lk_pc       = '0;
        bus.upd_en      = 1'b0;
        bus.upd_pc      = '0;
        bus.upd_state   = 2'b00;
        bus.upd_taken   = 1'b0;
        bus.upd_target  = '0;
        bus4.lk_pc      = '0;
        bus4.upd_en     = 1'b0;
        bus4.upd_pc     = '0;
        bus4.upd_state  = 2'b00;
        bus4.upd_taken  = 1'b0;
        bus4.upd_target = '0;

        test_reset();
        test_cold_alloc();
        test_saturation();
        test_alias();
        test_same_cycle();
        test_clear();
        test_reset_mid();
        test_cnt_sat();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
